// File: rtl/uart_arb_pkg.sv
// ----------------------------------------------------------------------------
// uart_arb_pkg
// Shared types and constants for the UART transmit arbiter.
//   state_t  : arbiter FSM states
//   CHAR_*   : ASCII constants used by requesters to build messages
// ----------------------------------------------------------------------------
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_START   = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_WAIT_LO = 3'd4,
        ST_NEXT    = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [7:0] CHAR_0 = 8'h30;
    localparam logic [7:0] CHAR_E = 8'h45;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] LF     = 8'h0A;

endpackage : uart_arb_pkg

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first active request at or after the
// pointer, wrapping from NREQ-1 back to 0.
//   req_i  in  NREQ  request vector
//   ptr_i  in  PW    highest-priority requester index
//   win_c  out NREQ  one-hot winner (zero when no request)
//   idx_c  out PW    winner index
//   any_c  out 1     at least one request active
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] win_c,
    output logic [PW-1:0]   idx_c,
    output logic            any_c
);

    logic [PW:0] cand_c;

    // Scan candidates in rotational order starting at the pointer.
    always_comb begin : pick
        win_c  = '0;
        idx_c  = '0;
        any_c  = 1'b0;
        cand_c = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand_c = (PW+1)'(ptr_i) + (PW+1)'(off);
            if (cand_c >= (PW+1)'(NREQ)) begin
                cand_c = cand_c - (PW+1)'(NREQ);
            end
            if (!any_c && req_i[cand_c[PW-1:0]]) begin
                any_c                = 1'b1;
                win_c[cand_c[PW-1:0]] = 1'b1;
                idx_c                = cand_c[PW-1:0];
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter among NREQ requesters. Round-robin grant; each
// grant sends one latched message of 0..MAXLEN bytes (byte 0 first), one byte
// per transmitter start/busy handshake, then pulses done for the winner.
//   clk, reset   clock, asynchronous active-low reset
//   req          per-requester level request
//   len          per-requester byte count, requester i at [i*LW +: LW]
//   msg          per-requester bytes, requester i byte k at [(i*MAXLEN+k)*8 +: 8]
//   gnt          one-hot grant, held for the whole message
//   done         one-cycle pulse at the end of the granted message
//   txd_start    one-cycle start pulse to the transmitter
//   txd_data     byte to the transmitter, held until the next start
//   txd_busy     transmitter busy
//   busy         arbiter not idle
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MAXLEN  = 4,
    parameter int unsigned LW      = 3,
    parameter int unsigned BUSY_TO = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*LW-1:0]       len,
    input  logic [NREQ*MAXLEN*8-1:0] msg,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic                     txd_start,
    output logic [7:0]               txd_data,
    input  logic                     txd_busy,
    output logic                     busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(BUSY_TO + 1);
    localparam int unsigned BW = MAXLEN * 8;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            start_q, start_d;
    logic [7:0]      data_q, data_d;
    logic            busy_q, busy_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   k_q, k_d;
    logic [TW-1:0]   to_q, to_d;

    logic [NREQ-1:0] win_c;
    logic [PW-1:0]   win_idx_c;
    logic            any_c;
    logic [BW-1:0]   sel_msg_c;
    logic [LW-1:0]   sel_len_c;
    logic [7:0]      cur_byte_c;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req_i (req),
        .ptr_i (rr_q),
        .win_c (win_c),
        .idx_c (win_idx_c),
        .any_c (any_c)
    );

    // Winner's message and clamped length, ready to latch at grant.
    always_comb begin : sel_winner
        sel_msg_c = '0;
        sel_len_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win_c[i]) begin
                sel_msg_c = msg[i*BW +: BW];
                sel_len_c = len[i*LW +: LW];
            end
        end
        if (sel_len_c > LW'(MAXLEN)) begin
            sel_len_c = LW'(MAXLEN);
        end
    end

    // Byte k of the latched message.
    always_comb begin : sel_byte
        cur_byte_c = '0;
        for (int unsigned b = 0; b < MAXLEN; b++) begin
            if (k_q == LW'(b)) begin
                cur_byte_c = buf_q[b*8 +: 8];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin : fsm_next
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        start_d = 1'b0;
        data_d  = data_q;
        rr_d    = rr_q;
        buf_d   = buf_q;
        len_d   = len_q;
        k_d     = k_q;
        to_d    = to_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_c) begin
                    buf_d   = sel_msg_c;
                    len_d   = sel_len_c;
                    gnt_d   = win_c;
                    rr_d    = (win_idx_c == PW'(NREQ - 1)) ? '0 : win_idx_c + PW'(1);
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                k_d     = '0;
                state_d = (len_q == '0) ? ST_DONE : ST_START;
            end
            ST_START: begin
                // Holds indefinitely while the transmitter is still busy.
                if (!txd_busy) begin
                    data_d  = cur_byte_c;
                    start_d = 1'b1;
                    to_d    = '0;
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                // A transmitter that never acknowledges still lets the message finish.
                if (txd_busy) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    to_d = to_q + TW'(1);
                    if (to_d == TW'(BUSY_TO)) begin
                        state_d = ST_NEXT;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (!txd_busy) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                k_d     = k_q + LW'(1);
                state_d = (k_d == len_q) ? ST_DONE : ST_START;
            end
            ST_DONE: begin
                done_d  = gnt_q;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin : regs
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            start_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            rr_q    <= '0;
            buf_q   <= '0;
            len_q   <= '0;
            k_q     <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            start_q <= start_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            rr_q    <= rr_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            k_q     <= k_d;
            to_q    <= to_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign txd_start = start_q;
    assign txd_data  = data_q;
    assign busy      = busy_q;

endmodule : uart_tx_arbiter
